// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared arbiter state encodings, default widths, tie-break helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2,
    ARB_LOCKED = 2'd3
  } arb_state_t;

  // On a tie the requester that was not served last wins.
  function automatic logic pick_ldr(input logic core_req, input logic ldr_req,
                                    input logic last_ldr);
    return ldr_req & (~core_req | ~last_ldr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_wait_cnt.sv
// ============================================================================
// arb_wait_cnt : loadable down-counter with zero flag (memory access hold)
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_wait_cnt
  import cpu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin memory arbiter between CPU core and loader port.
// Optional macro LDR_LOCK_EN adds ldr_lock and a LOCKED loader-ownership state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
`ifdef LDR_LOCK_EN
  input  logic          ldr_lock,
`endif
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_gnt,
  output logic          ldr_ack,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          clk_ena,
  output logic          busy
);

  localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(WAIT_CYC - 1);

  arb_state_t    r_state, w_state_nxt;
  logic          r_last_ldr, w_last_ldr_nxt;
  logic          r_sel_ldr, w_sel_ldr_nxt;
  logic          r_mem_cs, w_mem_cs_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DW-1:0] r_core_rdata, w_core_rdata_nxt;
  logic [DW-1:0] r_ldr_rdata, w_ldr_rdata_nxt;
  logic          r_core_ack, w_core_ack_nxt;
  logic          r_ldr_ack, w_ldr_ack_nxt;
  logic          r_ldr_gnt, w_ldr_gnt_nxt;
  logic          w_grant, w_grant_ldr;
  logic          w_cnt_load, w_cnt_dec, w_cnt_zero;

  arb_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk_in     (clk_in),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (c_wait_load),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_last_ldr   <= 1'b1;
      r_sel_ldr    <= 1'b0;
      r_mem_cs     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_ldr_rdata  <= '0;
      r_core_ack   <= 1'b0;
      r_ldr_ack    <= 1'b0;
      r_ldr_gnt    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_ldr   <= w_last_ldr_nxt;
      r_sel_ldr    <= w_sel_ldr_nxt;
      r_mem_cs     <= w_mem_cs_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_core_rdata <= w_core_rdata_nxt;
      r_ldr_rdata  <= w_ldr_rdata_nxt;
      r_core_ack   <= w_core_ack_nxt;
      r_ldr_ack    <= w_ldr_ack_nxt;
      r_ldr_gnt    <= w_ldr_gnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_ldr_nxt   = r_last_ldr;
    w_sel_ldr_nxt    = r_sel_ldr;
    w_mem_cs_nxt     = r_mem_cs;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_core_rdata_nxt = r_core_rdata;
    w_ldr_rdata_nxt  = r_ldr_rdata;
    w_core_ack_nxt   = 1'b0;
    w_ldr_ack_nxt    = 1'b0;
    w_ldr_gnt_nxt    = r_ldr_gnt;
    w_grant          = 1'b0;
    w_grant_ldr      = 1'b0;
    w_cnt_load       = 1'b0;
    w_cnt_dec        = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        w_grant     = core_req | ldr_req;
        w_grant_ldr = pick_ldr(core_req, ldr_req, r_last_ldr);
      end
      ARB_ACCESS: begin
        if (w_cnt_zero) begin
          if (!r_mem_we) begin
            if (r_sel_ldr) w_ldr_rdata_nxt = mem_rdata;
            else           w_core_rdata_nxt = mem_rdata;
          end
          w_mem_cs_nxt   = 1'b0;
          w_mem_we_nxt   = 1'b0;
          w_core_ack_nxt = ~r_sel_ldr;
          w_ldr_ack_nxt  = r_sel_ldr;
          w_state_nxt    = ARB_DONE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ARB_DONE: begin
        w_state_nxt   = ARB_IDLE;
        w_ldr_gnt_nxt = 1'b0;
`ifdef LDR_LOCK_EN
        if (r_sel_ldr && ldr_lock) begin
          w_state_nxt   = ARB_LOCKED;
          w_ldr_gnt_nxt = 1'b1;
        end
`endif
      end
`ifdef LDR_LOCK_EN
      ARB_LOCKED: begin
        // Once unlocked, arbitrate in this very cycle so a waiting core is not delayed.
        if (ldr_lock) begin
          w_grant     = ldr_req;
          w_grant_ldr = 1'b1;
        end else begin
          w_grant     = core_req | ldr_req;
          w_grant_ldr = pick_ldr(core_req, ldr_req, r_last_ldr);
          if (!w_grant) begin
            w_state_nxt   = ARB_IDLE;
            w_ldr_gnt_nxt = 1'b0;
          end
        end
      end
`endif
      default: begin
        w_state_nxt   = ARB_IDLE;
        w_mem_cs_nxt  = 1'b0;
        w_mem_we_nxt  = 1'b0;
        w_ldr_gnt_nxt = 1'b0;
      end
    endcase

    if (w_grant) begin
      w_state_nxt     = ARB_ACCESS;
      w_mem_cs_nxt    = 1'b1;
      w_mem_we_nxt    = w_grant_ldr ? ldr_we    : core_we;
      w_mem_addr_nxt  = w_grant_ldr ? ldr_addr  : core_addr;
      w_mem_wdata_nxt = w_grant_ldr ? ldr_wdata : core_wdata;
      w_cnt_load      = 1'b1;
      w_last_ldr_nxt  = w_grant_ldr;
      w_sel_ldr_nxt   = w_grant_ldr;
      w_ldr_gnt_nxt   = w_grant_ldr;
    end
  end

  assign core_rdata = r_core_rdata;
  assign core_ack   = r_core_ack;
  assign ldr_rdata  = r_ldr_rdata;
  assign ldr_ack    = r_ldr_ack;
  assign ldr_gnt    = r_ldr_gnt;
  assign mem_cs     = r_mem_cs;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign clk_ena    = ~(core_req & ~r_core_ack);
  assign busy       = (r_state != ARB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter (WAIT_CYC 1 and 3)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b0;
  always #5 clk_in = ~clk_in;

  // WAIT_CYC = 1 instance with a RAM model
  logic       core_req = 0, core_we = 0, ldr_req = 0, ldr_we = 0, ldr_lock = 0;
  logic [7:0] core_addr = 0, core_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
  logic [7:0] core_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       core_ack, ldr_ack, ldr_gnt, mem_cs, mem_we, clk_ena, busy;

  // WAIT_CYC = 3 instance, memory returns addr ^ 0x48
  logic       b_core_req = 0, b_ldr_req = 0, b_ldr_lock = 0;
  logic [7:0] b_ldr_addr = 0;
  logic [7:0] b_core_rdata, b_ldr_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic       b_core_ack, b_ldr_ack, b_ldr_gnt, b_mem_cs, b_mem_we, b_clk_ena, b_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_core_rd = 8'h00;
  logic [7:0] exp_ldr_rd  = 8'h00;

  mem_arbiter #(.AW(8), .DW(8), .WAIT_CYC(1)) u_dut (
    .clk_in(clk_in), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
`ifdef LDR_LOCK_EN
    .ldr_lock(ldr_lock),
`endif
    .ldr_rdata(ldr_rdata), .ldr_gnt(ldr_gnt), .ldr_ack(ldr_ack),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .clk_ena(clk_ena), .busy(busy)
  );

  mem_arbiter #(.AW(8), .DW(8), .WAIT_CYC(3)) u_dut3 (
    .clk_in(clk_in), .rst(rst),
    .core_req(b_core_req), .core_we(1'b0), .core_addr(8'h00), .core_wdata(8'h00),
    .core_rdata(b_core_rdata), .core_ack(b_core_ack),
    .ldr_req(b_ldr_req), .ldr_we(1'b0), .ldr_addr(b_ldr_addr), .ldr_wdata(8'h00),
`ifdef LDR_LOCK_EN
    .ldr_lock(b_ldr_lock),
`endif
    .ldr_rdata(b_ldr_rdata), .ldr_gnt(b_ldr_gnt), .ldr_ack(b_ldr_ack),
    .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .clk_ena(b_clk_ena), .busy(b_busy)
  );

  // RAM preloads to addr ^ 0x48 whenever reset is low
  logic [7:0] ram [256];
  always @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < 256; a++) ram[a] <= 8'(a) ^ 8'h48;
    end else if (mem_cs && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata   = ram[mem_addr];
  assign b_mem_rdata = b_mem_addr ^ 8'h48;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ack(input bit ldr, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ldr ? ldr_ack : core_ack) && n < 20);
    if (!(ldr ? ldr_ack : core_ack)) n = 99;
  endtask

  task automatic test_reset();
    core_req = 0; ldr_req = 0; rst = 0;
    tick(); tick();
    n_checks++;
    if ({mem_cs, mem_we, core_ack, ldr_ack, ldr_gnt, busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {mem_cs, mem_we, core_ack, ldr_ack, ldr_gnt, busy});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, core_rdata, ldr_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00000000", {mem_addr, mem_wdata, core_rdata, ldr_rdata});
    end
    #3 rst = 1;
    tick();
    n_checks++;
    if ({mem_cs, busy, clk_ena} !== 3'b001) begin
      n_fail++; $display("FAIL post_reset_idle: got %b expected 001", {mem_cs, busy, clk_ena});
    end
    exp_core_rd = 8'h00; exp_ldr_rd = 8'h00;
  endtask

  task automatic test_round_robin();
    int n;
    bit exp_ldr;
    for (int i = 0; i < 4; i++) begin
      exp_ldr = (i % 2) == 1;
      core_addr = 8'h20 + 8'(i); ldr_addr = 8'h30 + 8'(i);
      core_we = 0; ldr_we = 0; core_req = 1; ldr_req = 1;
      n = 0;
      do begin tick(); n++; end while (!(core_ack || ldr_ack) && n < 20);
      if (exp_ldr) exp_ldr_rd  = (8'h30 + 8'(i)) ^ 8'h48;
      else         exp_core_rd = (8'h20 + 8'(i)) ^ 8'h48;
      n_checks++;
      if ({core_ack, ldr_ack, ldr_gnt} !== (exp_ldr ? 3'b011 : 3'b100)) begin
        n_fail++; $display("FAIL rr_winner[%0d]: got ack/gnt %b expected %b", i, {core_ack, ldr_ack, ldr_gnt}, exp_ldr ? 3'b011 : 3'b100);
      end
      n_checks++;
      if (n !== 2) begin
        n_fail++; $display("FAIL rr_latency[%0d]: got %0d expected 2", i, n);
      end
      n_checks++;
      if ({core_rdata, ldr_rdata} !== {exp_core_rd, exp_ldr_rd}) begin
        n_fail++; $display("FAIL rr_rdata[%0d]: got %h/%h expected %h/%h", i, core_rdata, ldr_rdata, exp_core_rd, exp_ldr_rd);
      end
      core_req = 0; ldr_req = 0;
      tick();
    end
  endtask

  task automatic test_core_read();
    core_addr = 8'h12; core_we = 0; core_req = 1;
    #1;
    n_checks++;
    if (clk_ena !== 1'b0) begin
      n_fail++; $display("FAIL cr_clk_ena_req: got %b expected 0", clk_ena);
    end
    tick();
    n_checks++;
    if ({mem_cs, mem_we, mem_addr, core_ack, clk_ena, busy} !== {1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL cr_access: got cs=%b we=%b addr=%h ack=%b ena=%b busy=%b expected 1 0 12 0 0 1", mem_cs, mem_we, mem_addr, core_ack, clk_ena, busy);
    end
    tick();
    exp_core_rd = 8'h5A;
    n_checks++;
    if ({mem_cs, core_ack, clk_ena, core_rdata} !== {1'b0, 1'b1, 1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL cr_done: got cs=%b ack=%b ena=%b rdata=%h expected 0 1 1 5a", mem_cs, core_ack, clk_ena, core_rdata);
    end
    core_req = 0;
    tick();
    n_checks++;
    if ({core_ack, busy, ldr_rdata} !== {1'b0, 1'b0, exp_ldr_rd}) begin
      n_fail++; $display("FAIL cr_idle: got ack=%b busy=%b ldr_rdata=%h expected 0 0 %h", core_ack, busy, ldr_rdata, exp_ldr_rd);
    end
  endtask

  task automatic test_ldr_write_core_read();
    int n;
    ldr_addr = 8'h40; ldr_wdata = 8'hC3; ldr_we = 1; ldr_req = 1;
    tick();
    n_checks++;
    if ({ldr_gnt, mem_cs, mem_we, mem_addr, mem_wdata} !== {3'b111, 8'h40, 8'hC3}) begin
      n_fail++; $display("FAIL lw_access: got gnt=%b cs=%b we=%b addr=%h wd=%h expected 1 1 1 40 c3", ldr_gnt, mem_cs, mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_checks++;
    if ({ldr_ack, ldr_gnt, ldr_rdata, core_rdata} !== {2'b11, exp_ldr_rd, exp_core_rd}) begin
      n_fail++; $display("FAIL lw_done: got ack=%b gnt=%b rd=%h/%h expected 1 1 %h/%h", ldr_ack, ldr_gnt, ldr_rdata, core_rdata, exp_ldr_rd, exp_core_rd);
    end
    ldr_req = 0; ldr_we = 0;
    tick();
    n_checks++;
    if (ldr_gnt !== 1'b0) begin
      n_fail++; $display("FAIL lw_gnt_release: got %b expected 0", ldr_gnt);
    end
    core_addr = 8'h40; core_we = 0; core_req = 1;
    wait_ack(1'b0, n);
    exp_core_rd = 8'hC3;
    n_checks++;
    if ({n[7:0], core_rdata, ldr_rdata} !== {8'd2, 8'hC3, exp_ldr_rd}) begin
      n_fail++; $display("FAIL lw_core_readback: got lat=%0d rd=%h ldr_rd=%h expected 2 c3 %h", n, core_rdata, ldr_rdata, exp_ldr_rd);
    end
    core_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int n;
    bit seen_ack;
    core_addr = 8'h12; core_we = 0; core_req = 1;
    tick();
    #2 rst = 0;
    #1;
    n_checks++;
    if ({mem_cs, busy, core_ack} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid: got cs=%b busy=%b ack=%b expected 000", mem_cs, busy, core_ack);
    end
    core_req = 0;
    seen_ack = 0;
    @(posedge clk_in);
    #3 rst = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (core_ack || ldr_ack) seen_ack = 1;
    end
    n_checks++;
    if ({seen_ack, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rst_no_ack: got ack_seen=%b busy=%b expected 00", seen_ack, busy);
    end
    core_addr = 8'h21; core_req = 1;
    wait_ack(1'b0, n);
    n_checks++;
    if ({n[7:0], core_rdata, ldr_rdata} !== {8'd2, 8'h69, 8'h00}) begin
      n_fail++; $display("FAIL rst_fresh_read: got lat=%0d rd=%h ldr_rd=%h expected 2 69 00", n, core_rdata, ldr_rdata);
    end
    core_req = 0;
    tick();
  endtask

  task automatic test_wait3();
    int n;
    int cs_cnt;
    b_ldr_addr = 8'h07; b_ldr_req = 1;
    n = 0; cs_cnt = 0;
    do begin
      tick(); n++;
      if (b_mem_cs) cs_cnt++;
    end while (!b_ldr_ack && n < 20);
    n_checks++;
    if (n !== 4) begin
      n_fail++; $display("FAIL w3_latency: got %0d expected 4", n);
    end
    n_checks++;
    if (cs_cnt !== 3) begin
      n_fail++; $display("FAIL w3_cs_cycles: got %0d expected 3", cs_cnt);
    end
    n_checks++;
    if ({b_ldr_rdata, b_ldr_gnt, b_core_rdata} !== {8'h4F, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL w3_rdata: got rd=%h gnt=%b core_rd=%h expected 4f 1 00", b_ldr_rdata, b_ldr_gnt, b_core_rdata);
    end
    b_ldr_req = 0;
    tick();
    n_checks++;
    if ({b_ldr_gnt, b_busy} !== 2'b00) begin
      n_fail++; $display("FAIL w3_release: got gnt=%b busy=%b expected 00", b_ldr_gnt, b_busy);
    end
  endtask

`ifdef LDR_LOCK_EN
  task automatic test_lock();
    int n;
    ldr_lock = 1;
    for (int k = 0; k < 3; k++) begin
      ldr_addr = 8'h50 + 8'(k); ldr_wdata = 8'hD0 + 8'(k); ldr_we = 1; ldr_req = 1;
      if (k == 0) begin
        tick();
        core_addr = 8'h50; core_we = 0; core_req = 1;
      end
      wait_ack(1'b1, n);
      n_checks++;
      if ({n < 20, core_ack, clk_ena} !== 3'b100) begin
        n_fail++; $display("FAIL lock_wr[%0d]: got acked=%b core_ack=%b ena=%b expected 1 0 0", k, n < 20, core_ack, clk_ena);
      end
      ldr_req = 0;
      tick();
      n_checks++;
      if ({ldr_gnt, core_ack, clk_ena} !== 3'b100) begin
        n_fail++; $display("FAIL lock_hold[%0d]: got gnt=%b core_ack=%b ena=%b expected 1 0 0", k, ldr_gnt, core_ack, clk_ena);
      end
    end
    ldr_lock = 0; ldr_we = 0;
    wait_ack(1'b0, n);
    n_checks++;
    if ({n[7:0], core_rdata} !== {8'd2, 8'hD0}) begin
      n_fail++; $display("FAIL lock_release: got lat=%0d rd=%h expected 2 d0", n, core_rdata);
    end
    core_req = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_core_read();
    test_ldr_write_core_read();
    test_reset_mid_access();
    test_wait3();
`ifdef LDR_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
